fpu_wb_ctrl: RTL and testbench
==============================

Name: fpu_wb_ctrl

Overview:
FP writeback controller and fcsr owner. Sits between the FPU execution unit and the FP register file. Receives the FPU result through its held-valid/ready handshake and FP load results from the LSU, and arbitrates both onto the single FP register-file write port. Owns the accrued fflags and frm state of fcsr, including CSR-instruction updates.

Parameters:
DATA_W, 64, FP register data width
ADDR_W, 5, register address width
CID_W, 3, commit ID width
STARVE_MAX, 3, consecutive LSU wins tolerated before the FPU is forced to win (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fpu_we_i  in  1  FPU result valid; held until handshake
fpu_waddr_i  in  ADDR_W  FPU destination register
fpu_wdata_i  in  DATA_W  FPU result data
fpu_fcsr_we_i  in  1  FPU result carries nonzero exception flags
fpu_fflags_i  in  5  FPU exception flags {NV,DZ,OF,UF,NX}
fpu_commit_id_i  in  CID_W  FPU instruction commit ID
fpu_wb_ready_o  out  1  FPU result accepted this cycle
lsu_we_i  in  1  FP load result valid; held until handshake
lsu_waddr_i  in  ADDR_W  load destination register
lsu_wdata_i  in  DATA_W  load data
lsu_commit_id_i  in  CID_W  load commit ID
lsu_wb_ready_o  out  1  load result accepted this cycle
freg_we_o  out  1  FP register-file write enable
freg_waddr_o  out  ADDR_W  FP register-file write address
freg_wdata_o  out  DATA_W  FP register-file write data
commit_valid_o  out  1  one instruction retired (pulse)
commit_id_o  out  CID_W  ID of the retired instruction
csr_we_i  in  1  CSR instruction write strobe
csr_sel_i  in  2  CSR target: 00 none, 01 fflags, 10 frm, 11 fcsr
csr_wdata_i  in  8  CSR write value; fcsr = {frm[2:0], fflags[4:0]}
csr_frm_o  out  3  current rounding mode
csr_fflags_o  out  5  current accrued flags
fcsr_o  out  8  {frm, fflags}

Behaviour:
- Reset (async): freg_we_o, freg_waddr_o, freg_wdata_o, commit_valid_o, commit_id_o = 0; frm = 0; fflags = 0; starve counter = 0. A reset mid-handshake discards the transfer; nothing is written.
- Grant (combinational):
  - Only one source valid: that source wins.
  - Both valid: LSU wins unless starve_cnt == STARVE_MAX, in which case the FPU wins.
- Ready outputs: fpu_wb_ready_o = fpu_we_i & fpu_grant; lsu_wb_ready_o = lsu_we_i & lsu_grant. Never both high in one cycle. Never high without the matching valid.
- Handshake = valid & ready. Sources hold all fields stable until the handshake. The controller samples the fields only in the handshake cycle.
- Starve counter:
  - Increments (saturating at STARVE_MAX) when both sources are valid and the LSU wins.
  - Clears when the FPU wins or fpu_we_i = 0.
  - Holds otherwise.
- Output stage (registered, latency 1 from handshake):
  - On a handshake: freg_we_o = 1; waddr, wdata and commit_id come from the winner; commit_valid_o = 1.
  - No handshake: freg_we_o = 0 and commit_valid_o = 0 next cycle. waddr, wdata and commit_id hold their last values.
  - Back-to-back handshakes give back-to-back writes; throughput is 1 per cycle.
- fflags next value = base | acc.
  - base = csr_wdata_i[4:0] if csr_we_i & csr_sel_i ∈ {01,11}; otherwise current fflags.
  - acc = fpu_fflags_i if the FPU handshakes with fpu_fcsr_we_i = 1; otherwise 0.
  - Flags are sticky and are cleared only by a CSR write.
- frm next value = csr_wdata_i[7:5] if csr_we_i & csr_sel_i = 11; csr_wdata_i[2:0] if csr_sel_i = 10; otherwise hold. The FPU never modifies frm.
- csr_we_i with csr_sel_i = 00 is a no-op.
- CSR and FPU flag update in the same cycle: the OR above applies, so FPU flags always survive.
- csr_* and fcsr_o outputs are register outputs; an update becomes visible the cycle after it occurs.
- An FPU handshake with fpu_fcsr_we_i = 0 leaves fflags unchanged, even if fpu_fflags_i is nonzero.

Test Plan:
- Reset released, no traffic: all outputs 0 (fcsr_o = 8'h00) and both readies 0 for 10 cycles.
- FPU only: fpu_we_i = 1, waddr = 5, wdata = 64'h3FF0000000000000, fflags = 5'b00001, fcsr_we = 1, commit_id = 2.
  - Required: fpu_wb_ready_o = 1 in the same cycle.
  - Required next cycle: freg_we_o = 1, waddr = 5, commit_valid_o = 1, commit_id_o = 2, fflags = 5'b00001.
- Both sources valid continuously, STARVE_MAX = 3: LSU wins cycles 0, 1, 2; FPU wins cycle 3; LSU wins cycle 4 once the FPU drops valid.
- fflags = 5'b10000, then in one cycle a CSR write sel = 01, wdata = 8'h00 and an FPU handshake with fflags = 5'b00100, fcsr_we = 1 -> fflags = 5'b00100 next cycle.
- CSR write sel = 11, wdata = 8'hE3 -> frm = 3'b111, fflags = 5'b00011. Then sel = 10, wdata = 8'h01 -> frm = 3'b001, fflags unchanged.
- Assert rst_n low during an FPU handshake cycle -> freg_we_o = 0, counter = 0, and no register write occurs after reset release.

Source files
------------

// File: rtl/fpu_wb_ctrl_if.sv
// Writeback bus between the FPU / LSU result sources, the FP register file
// and the commit tracker.
//   fpu_*   : FPU result source (held-valid / ready handshake)
//   lsu_*   : FP load result source (held-valid / ready handshake)
//   freg_*  : FP register-file write port
//   commit_*: retirement pulse and ID
// Modports: master = source/sink environment, slave = fpu_wb_ctrl.
interface fpu_wb_ctrl_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CID_W  = 3
);
  logic              fpu_we_i;
  logic [ADDR_W-1:0] fpu_waddr_i;
  logic [DATA_W-1:0] fpu_wdata_i;
  logic              fpu_fcsr_we_i;
  logic [4:0]        fpu_fflags_i;
  logic [CID_W-1:0]  fpu_commit_id_i;
  logic              fpu_wb_ready_o;

  logic              lsu_we_i;
  logic [ADDR_W-1:0] lsu_waddr_i;
  logic [DATA_W-1:0] lsu_wdata_i;
  logic [CID_W-1:0]  lsu_commit_id_i;
  logic              lsu_wb_ready_o;

  logic              freg_we_o;
  logic [ADDR_W-1:0] freg_waddr_o;
  logic [DATA_W-1:0] freg_wdata_o;
  logic              commit_valid_o;
  logic [CID_W-1:0]  commit_id_o;

  modport master (
    output fpu_we_i, fpu_waddr_i, fpu_wdata_i, fpu_fcsr_we_i, fpu_fflags_i, fpu_commit_id_i,
    input  fpu_wb_ready_o,
    output lsu_we_i, lsu_waddr_i, lsu_wdata_i, lsu_commit_id_i,
    input  lsu_wb_ready_o,
    input  freg_we_o, freg_waddr_o, freg_wdata_o, commit_valid_o, commit_id_o
  );

  modport slave (
    input  fpu_we_i, fpu_waddr_i, fpu_wdata_i, fpu_fcsr_we_i, fpu_fflags_i, fpu_commit_id_i,
    output fpu_wb_ready_o,
    input  lsu_we_i, lsu_waddr_i, lsu_wdata_i, lsu_commit_id_i,
    output lsu_wb_ready_o,
    output freg_we_o, freg_waddr_o, freg_wdata_o, commit_valid_o, commit_id_o
  );
endinterface

// File: rtl/fpu_wb_ctrl.sv
// FP writeback controller and fcsr owner.
// Arbitrates FPU results and FP load results onto the single FP register-file
// write port (LSU priority with an FPU anti-starvation override), registers
// the write/commit outputs (latency 1), and holds the frm / accrued fflags
// state of fcsr, updated by CSR instructions and by FPU exception flags.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : FPU/LSU handshakes, register-file write, commit pulse
//   csr_we_i/sel_i/wdata_i : CSR write strobe, target (01 fflags, 10 frm, 11 fcsr), value
//   csr_frm_o, csr_fflags_o, fcsr_o : current fcsr state
module fpu_wb_ctrl #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned CID_W      = 3,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  fpu_wb_ctrl_if.slave  bus,
  input  logic          csr_we_i,
  input  logic [1:0]    csr_sel_i,
  input  logic [7:0]    csr_wdata_i,
  output logic [2:0]    csr_frm_o,
  output logic [4:0]    csr_fflags_o,
  output logic [7:0]    fcsr_o
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0]        starve_q, starve_d;
  logic              fpu_grant, lsu_grant;
  logic              fpu_hs, lsu_hs;

  logic              freg_we_q;
  logic [ADDR_W-1:0] freg_waddr_q, freg_waddr_d;
  logic [DATA_W-1:0] freg_wdata_q, freg_wdata_d;
  logic              commit_valid_q;
  logic [CID_W-1:0]  commit_id_q, commit_id_d;

  logic [4:0]        fflags_q, fflags_d, fflags_base, fflags_acc;
  logic [2:0]        frm_q, frm_d;

  // Arbitration: LSU normally wins a tie; once the FPU has lost STARVE_MAX
  // consecutive ties it is granted instead.
  always_comb begin
    fpu_grant = bus.fpu_we_i & (~bus.lsu_we_i | (starve_q == StarveMax));
    lsu_grant = bus.lsu_we_i & ~fpu_grant;
  end

  // Grants already include the valids, so grant == handshake.
  assign fpu_hs             = fpu_grant;
  assign lsu_hs             = lsu_grant;
  assign bus.fpu_wb_ready_o = fpu_hs;
  assign bus.lsu_wb_ready_o = lsu_hs;

  always_comb begin
    starve_d = starve_q;
    if (!bus.fpu_we_i || fpu_grant) begin
      starve_d = '0;
    end else if (lsu_grant) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
    end
  end

  // Write-port payload: take the winner's fields, otherwise hold.
  always_comb begin
    freg_waddr_d = freg_waddr_q;
    freg_wdata_d = freg_wdata_q;
    commit_id_d  = commit_id_q;
    if (fpu_hs) begin
      freg_waddr_d = bus.fpu_waddr_i;
      freg_wdata_d = bus.fpu_wdata_i;
      commit_id_d  = bus.fpu_commit_id_i;
    end else if (lsu_hs) begin
      freg_waddr_d = bus.lsu_waddr_i;
      freg_wdata_d = bus.lsu_wdata_i;
      commit_id_d  = bus.lsu_commit_id_i;
    end
  end

  // fflags: CSR write replaces the base, FPU flags are ORed on top so they
  // are never lost to a same-cycle CSR write.
  always_comb begin
    fflags_base = fflags_q;
    if (csr_we_i && csr_sel_i[0]) begin
      fflags_base = csr_wdata_i[4:0];
    end
    fflags_acc = (fpu_hs && bus.fpu_fcsr_we_i) ? bus.fpu_fflags_i : 5'b0;
    fflags_d   = fflags_base | fflags_acc;
  end

  always_comb begin
    frm_d = frm_q;
    if (csr_we_i) begin
      unique case (csr_sel_i)
        2'b11:   frm_d = csr_wdata_i[7:5];
        2'b10:   frm_d = csr_wdata_i[2:0];
        default: frm_d = frm_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q       <= '0;
      freg_we_q      <= 1'b0;
      freg_waddr_q   <= '0;
      freg_wdata_q   <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      fflags_q       <= '0;
      frm_q          <= '0;
    end else begin
      starve_q       <= starve_d;
      freg_we_q      <= fpu_hs | lsu_hs;
      freg_waddr_q   <= freg_waddr_d;
      freg_wdata_q   <= freg_wdata_d;
      commit_valid_q <= fpu_hs | lsu_hs;
      commit_id_q    <= commit_id_d;
      fflags_q       <= fflags_d;
      frm_q          <= frm_d;
    end
  end

  assign bus.freg_we_o      = freg_we_q;
  assign bus.freg_waddr_o   = freg_waddr_q;
  assign bus.freg_wdata_o   = freg_wdata_q;
  assign bus.commit_valid_o = commit_valid_q;
  assign bus.commit_id_o    = commit_id_q;

  assign csr_frm_o    = frm_q;
  assign csr_fflags_o = fflags_q;
  assign fcsr_o       = {frm_q, fflags_q};

endmodule

// File: tb/tb_fpu_wb_ctrl.sv
// Directed self-checking bench for fpu_wb_ctrl: reset state, FPU-only write,
// LSU/FPU arbitration with starvation override, fflags/frm CSR updates and a
// reset asserted during an FPU handshake.
module tb_fpu_wb_ctrl;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CID_W  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       csr_we;
  logic [1:0] csr_sel;
  logic [7:0] csr_wdata;
  logic [2:0] csr_frm;
  logic [4:0] csr_fflags;
  logic [7:0] fcsr;

  int checks   = 0;
  int failures = 0;

  fpu_wb_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CID_W(CID_W)) bus ();

  fpu_wb_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CID_W(CID_W), .STARVE_MAX(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .csr_we_i     (csr_we),
    .csr_sel_i    (csr_sel),
    .csr_wdata_i  (csr_wdata),
    .csr_frm_o    (csr_frm),
    .csr_fflags_o (csr_fflags),
    .fcsr_o       (fcsr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fpu_we_i      = 1'b0;
    bus.fpu_fcsr_we_i = 1'b0;
    bus.fpu_fflags_i  = 5'b0;
    bus.lsu_we_i      = 1'b0;
    csr_we            = 1'b0;
    csr_sel           = 2'b00;
    csr_wdata         = 8'h00;
  endtask

  task automatic drive_fpu(input logic [4:0] a, input logic [63:0] d, input logic [4:0] fl,
                           input logic fwe, input logic [2:0] cid);
    bus.fpu_we_i        = 1'b1;
    bus.fpu_waddr_i     = a;
    bus.fpu_wdata_i     = d;
    bus.fpu_fflags_i    = fl;
    bus.fpu_fcsr_we_i   = fwe;
    bus.fpu_commit_id_i = cid;
  endtask

  task automatic drive_lsu(input logic [4:0] a, input logic [63:0] d, input logic [2:0] cid);
    bus.lsu_we_i        = 1'b1;
    bus.lsu_waddr_i     = a;
    bus.lsu_wdata_i     = d;
    bus.lsu_commit_id_i = cid;
  endtask

  task automatic csr_write(input logic [1:0] sel, input logic [7:0] val);
    csr_we    = 1'b1;
    csr_sel   = sel;
    csr_wdata = val;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.fpu_waddr_i = '0; bus.fpu_wdata_i = '0; bus.fpu_commit_id_i = '0;
    bus.lsu_waddr_i = '0; bus.lsu_wdata_i = '0; bus.lsu_commit_id_i = '0;
    #21 rst_n = 1'b1;

    // Reset released, no traffic for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_freg_we", bus.freg_we_o, 0);
      check("idle_waddr", bus.freg_waddr_o, 0);
      check("idle_wdata", bus.freg_wdata_o, 0);
      check("idle_commit_valid", bus.commit_valid_o, 0);
      check("idle_commit_id", bus.commit_id_o, 0);
      check("idle_fcsr", fcsr, 8'h00);
      check("idle_fpu_ready", bus.fpu_wb_ready_o, 0);
      check("idle_lsu_ready", bus.lsu_wb_ready_o, 0);
    end

    // FPU only.
    drive_fpu(5'd5, 64'h3FF0000000000000, 5'b00001, 1'b1, 3'd2);
    #1;
    check("fpu_only_ready", bus.fpu_wb_ready_o, 1);
    check("fpu_only_lsu_ready", bus.lsu_wb_ready_o, 0);
    tick();
    idle();
    check("fpu_only_we", bus.freg_we_o, 1);
    check("fpu_only_waddr", bus.freg_waddr_o, 5);
    check("fpu_only_wdata", bus.freg_wdata_o, 64'h3FF0000000000000);
    check("fpu_only_cvalid", bus.commit_valid_o, 1);
    check("fpu_only_cid", bus.commit_id_o, 2);
    check("fpu_only_fflags", csr_fflags, 5'b00001);
    check("fpu_only_fcsr", fcsr, 8'h01);
    tick();
    check("after_fpu_we", bus.freg_we_o, 0);
    check("after_fpu_cvalid", bus.commit_valid_o, 0);
    check("after_fpu_waddr_hold", bus.freg_waddr_o, 5);
    check("after_fpu_cid_hold", bus.commit_id_o, 2);

    // Both valid: LSU wins 3 times, then FPU (its flags carry no fcsr_we).
    drive_fpu(5'd7, 64'hAAAA, 5'b11111, 1'b0, 3'd3);
    for (int i = 0; i < 3; i++) begin
      drive_lsu(5'(9 + i), 64'(16'hB000 + i), 3'(4 + i));
      #1;
      check("starve_lsu_ready", bus.lsu_wb_ready_o, 1);
      check("starve_fpu_ready", bus.fpu_wb_ready_o, 0);
      tick();
      check("starve_lsu_waddr", bus.freg_waddr_o, 9 + i);
      check("starve_lsu_wdata", bus.freg_wdata_o, 16'hB000 + i);
      check("starve_lsu_cid", bus.commit_id_o, 4 + i);
      check("starve_lsu_we", bus.freg_we_o, 1);
    end
    drive_lsu(5'd12, 64'hC0C0, 3'd7);
    #1;
    check("force_fpu_ready", bus.fpu_wb_ready_o, 1);
    check("force_lsu_ready", bus.lsu_wb_ready_o, 0);
    tick();
    bus.fpu_we_i = 1'b0;
    check("force_fpu_waddr", bus.freg_waddr_o, 7);
    check("force_fpu_wdata", bus.freg_wdata_o, 64'hAAAA);
    check("force_fpu_cid", bus.commit_id_o, 3);
    check("no_fcsr_we_fflags", csr_fflags, 5'b00001);
    #1;
    check("lsu_after_fpu_ready", bus.lsu_wb_ready_o, 1);
    tick();
    idle();
    check("lsu_after_fpu_waddr", bus.freg_waddr_o, 12);
    check("lsu_after_fpu_cid", bus.commit_id_o, 7);

    // fflags: set to 10000, then CSR clear concurrent with FPU flags 00100.
    csr_write(2'b01, 8'h10);
    #1;
    check("fflags_not_yet", csr_fflags, 5'b00001);
    tick();
    idle();
    check("fflags_set", csr_fflags, 5'b10000);
    check("frm_untouched", csr_frm, 3'b000);
    csr_write(2'b01, 8'h00);
    drive_fpu(5'd3, 64'h1, 5'b00100, 1'b1, 3'd1);
    tick();
    idle();
    check("fflags_or_csr", csr_fflags, 5'b00100);
    csr_write(2'b00, 8'hFF);
    tick();
    idle();
    check("sel00_noop", fcsr, 8'h04);

    // fcsr write, then frm write.
    csr_write(2'b11, 8'hE3);
    tick();
    idle();
    check("fcsr_frm", csr_frm, 3'b111);
    check("fcsr_fflags", csr_fflags, 5'b00011);
    check("fcsr_full", fcsr, 8'hE3);
    csr_write(2'b10, 8'h01);
    tick();
    idle();
    check("frm_write", csr_frm, 3'b001);
    check("frm_write_fflags", csr_fflags, 5'b00011);
    check("frm_write_fcsr", fcsr, 8'h23);

    // Reset during an FPU handshake with the starve counter saturated.
    drive_fpu(5'd20, 64'hDEAD, 5'b01000, 1'b1, 3'd5);
    for (int i = 0; i < 3; i++) begin
      drive_lsu(5'(1 + i), 64'(i), 3'(i));
      tick();
    end
    #1;
    check("pre_reset_fpu_ready", bus.fpu_wb_ready_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_freg_we", bus.freg_we_o, 0);
    check("rst_cvalid", bus.commit_valid_o, 0);
    check("rst_fcsr", fcsr, 8'h00);
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_freg_we", bus.freg_we_o, 0);
    check("post_rst_cvalid", bus.commit_valid_o, 0);
    check("post_rst_fflags", csr_fflags, 5'b00000);
    check("post_rst_waddr", bus.freg_waddr_o, 0);
    drive_fpu(5'd21, 64'hBEEF, 5'b0, 1'b0, 3'd6);
    drive_lsu(5'd22, 64'hF00D, 3'd2);
    #1;
    check("post_rst_cnt_lsu_ready", bus.lsu_wb_ready_o, 1);
    check("post_rst_cnt_fpu_ready", bus.fpu_wb_ready_o, 0);
    tick();
    idle();
    check("post_rst_lsu_waddr", bus.freg_waddr_o, 22);
    check("post_rst_lsu_we", bus.freg_we_o, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
